mem_store_buffer: RTL and testbench

//  Store buffer between EX/MEM pipeline register and the single-port 8-bit data memory.

---
 rtl/mem_store_buffer.sv | 107 ++++++++++
 tb/tb_mem_store_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// In-order store buffer in front of a single-port byte memory. Drains one store per
// cycle when the port is free, forwards the youngest matching store to loads.
module mem_store_buffer #(
  parameter int ADDRESS_LINE = 8,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      st_valid,
  input  logic [ADDRESS_LINE-1:0]   st_address,
  input  logic [7:0]                st_data,
  output logic                      st_ready,
  input  logic                      ld_valid,
  input  logic [ADDRESS_LINE-1:0]   ld_address,
  output logic [7:0]                ld_data,
  output logic                      ld_hit,
  output logic                      ld_stall,
  output logic [ADDRESS_LINE-1:0]   mem_address,
  output logic                      mem_write,
  output logic [7:0]                mem_write_data,
  output logic                      mem_read,
  input  logic [7:0]                mem_read_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      buffer_empty
);
  // Handshake: a store is accepted on any posedge where st_valid && st_ready;
  // st_ready depends only on occupancy, never on a same-cycle drain.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDRESS_LINE-1:0] addr_q [DEPTH];
  logic [7:0]              data_q [DEPTH];
  logic [DEPTH-1:0]        valid_q;
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [STV_W-1:0]        starve_cnt;
  logic                    push;
  logic                    pop;
  logic                    force_drain;
  logic                    fwd_hit;
  logic [7:0]              fwd_data;
  logic [PTR_W-1:0]        idx;

  assign buffer_empty = (count == '0);
  assign st_ready     = (count < CNT_W'(DEPTH));
  assign force_drain  = (starve_cnt == STV_W'(STARVE_LIMIT));
  assign push         = st_valid && st_ready;
  assign pop          = !buffer_empty && (!ld_valid || force_drain);
  assign ld_stall     = ld_valid && force_drain;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx] == ld_address)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign ld_hit         = ld_valid && fwd_hit;
  assign mem_read       = ld_valid && !fwd_hit && !force_drain;
  assign mem_write      = pop;
  assign mem_write_data = data_q[head];
  assign mem_address    = mem_read ? ld_address : addr_q[head];

  always_comb begin
    ld_data = '0;
    if (ld_valid) begin
      if (fwd_hit)       ld_data = fwd_data;
      else if (mem_read) ld_data = mem_read_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
      valid_q    <= '0;
    end else begin
      if (push) begin
        addr_q[tail]  <= st_address;
        data_q[tail]  <= st_data;
        valid_q[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      // Blocked-cycle counter; saturates because force_drain gates the increment.
      if (pop || buffer_empty)
        starve_cnt <= '0;
      else if (ld_valid && !force_drain)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer with a byte-memory model and an in-order
// write scoreboard fed by hand-written expected {address,data} pairs.
module tb_mem_store_buffer;
  localparam int AW = 8;
  localparam int SL = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          st_valid;
  logic [AW-1:0] st_address;
  logic [7:0]    st_data;
  logic          st_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_address;
  logic [7:0]    ld_data;
  logic          ld_hit;
  logic          ld_stall;
  logic [AW-1:0] mem_address;
  logic          mem_write;
  logic [7:0]    mem_write_data;
  logic          mem_read;
  logic [7:0]    mem_read_data;
  logic [2:0]    count;
  logic          buffer_empty;

  logic [7:0]    mem [256];
  logic [15:0]   exp_q [$];
  int            checks   = 0;
  int            failures = 0;

  mem_store_buffer #(.ADDRESS_LINE(AW), .DEPTH(4), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .st_valid(st_valid), .st_address(st_address), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_address(ld_address), .ld_data(ld_data),
    .ld_hit(ld_hit), .ld_stall(ld_stall),
    .mem_address(mem_address), .mem_write(mem_write), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_read_data(mem_read_data),
    .count(count), .buffer_empty(buffer_empty)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // data memory model
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
  always @(posedge clock) if (mem_write === 1'b1) mem[mem_address] <= mem_write_data;
  assign mem_read_data = mem[mem_address];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every memory write must match the next expected pair
  always @(negedge clock) begin
    if (reset === 1'b1 && mem_write === 1'b1) begin
      check("rw_excl", 32'(mem_read), 32'd0);
      if (exp_q.size() == 0) check("wr_unexp", {24'd0, mem_address}, 32'hFFFF);
      else check("wr_order", {16'd0, mem_address, mem_write_data}, {16'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_store(input logic v, input logic [7:0] a, input logic [7:0] d);
    st_valid = v; st_address = a; st_data = d;
  endtask

  task automatic set_load(input logic v, input logic [7:0] a);
    ld_valid = v; ld_address = a;
  endtask

  initial begin
    // 1: reset held with a store offered
    reset = 1'b0;
    set_store(1'b1, 8'hAA, 8'h55);
    set_load(1'b0, 8'h00);
    tick(); tick();
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(st_ready), 32'd1);
    check("rst_empty", 32'(buffer_empty), 32'd1);
    check("rst_wr", 32'(mem_write), 32'd0);
    check("rst_hit", 32'(ld_hit), 32'd0);
    check("rst_stall", 32'(ld_stall), 32'd0);
    set_store(1'b0, 8'h00, 8'h00);
    reset = 1'b1;
    tick();

    // 2: three back-to-back stores drain one per cycle
    exp_q.push_back(16'h1011); exp_q.push_back(16'h1122); exp_q.push_back(16'h1233);
    set_store(1'b1, 8'h10, 8'h11);
    tick(); #1;
    check("t2_cnt_a", 32'(count), 32'd1);
    check("t2_wr_a", 32'(mem_write), 32'd1);
    check("t2_addr_a", 32'(mem_address), 32'h10);
    set_store(1'b1, 8'h11, 8'h22);
    tick(); #1;
    check("t2_cnt_b", 32'(count), 32'd1);
    set_store(1'b1, 8'h12, 8'h33);
    tick(); #1;
    check("t2_cnt_c", 32'(count), 32'd1);
    set_store(1'b0, 8'h00, 8'h00);
    tick(); #1;
    check("t2_empty", 32'(buffer_empty), 32'd1);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // 3: fill while a missing load holds the port, then release
    set_load(1'b1, 8'h80);
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 8'h20 + 8'(i), 8'hA0 + 8'(i));
      tick();
    end
    #1;
    check("t3_full_cnt", 32'(count), 32'd4);
    check("t3_full_rdy", 32'(st_ready), 32'd0);
    set_store(1'b1, 8'h24, 8'hA4);
    tick(); #1;
    check("t3_ignored", 32'(count), 32'd4);
    check("t3_miss_hit", 32'(ld_hit), 32'd0);
    check("t3_miss_rd", 32'(mem_read), 32'd1);
    check("t3_miss_data", 32'(ld_data), 32'hDA);
    set_store(1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) exp_q.push_back({8'h20 + 8'(i), 8'hA0 + 8'(i)});
    set_load(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    #1;
    check("t3_cnt", 32'(count), 32'd0);
    check("t3_ready", 32'(st_ready), 32'd1);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // 4: forwarding picks the youngest of two matching stores
    set_load(1'b1, 8'h90);
    set_store(1'b1, 8'h05, 8'h10);
    tick();
    set_store(1'b1, 8'h05, 8'h20);
    tick();
    set_store(1'b0, 8'h00, 8'h00);
    set_load(1'b1, 8'h05);
    #1;
    check("t4_hit", 32'(ld_hit), 32'd1);
    check("t4_data", 32'(ld_data), 32'h20);
    check("t4_rd", 32'(mem_read), 32'd0);
    set_load(1'b1, 8'h06);
    #1;
    check("t4_miss_hit", 32'(ld_hit), 32'd0);
    check("t4_miss_rd", 32'(mem_read), 32'd1);
    check("t4_miss_addr", 32'(mem_address), 32'h06);
    check("t4_miss_data", 32'(ld_data), 32'h5C);
    exp_q.push_back(16'h0510); exp_q.push_back(16'h0520);
    set_load(1'b0, 8'h00);
    tick(); tick();
    set_load(1'b1, 8'h05);
    #1;
    check("t4_mem_hit", 32'(ld_hit), 32'd0);
    check("t4_mem_data", 32'(ld_data), 32'h20);
    set_load(1'b0, 8'h05);
    #1;
    check("t4_idle_data", 32'(ld_data), 32'd0);

    // 5: a store starved by a continuous load is forced out
    set_load(1'b1, 8'h40);
    set_store(1'b1, 8'h30, 8'h77);
    tick();
    set_store(1'b0, 8'h00, 8'h00);
    for (int i = 0; i < SL - 1; i++) begin
      tick(); #1;
      check("t5_no_stall", 32'(ld_stall), 32'd0);
    end
    exp_q.push_back(16'h3077);
    tick(); #1;
    check("t5_stall", 32'(ld_stall), 32'd1);
    check("t5_wr", 32'(mem_write), 32'd1);
    check("t5_addr", 32'(mem_address), 32'h30);
    check("t5_rd", 32'(mem_read), 32'd0);
    tick(); #1;
    check("t5_unstall", 32'(ld_stall), 32'd0);
    check("t5_cnt", 32'(count), 32'd0);
    check("t5_rd_after", 32'(mem_read), 32'd1);
    check("t5_data_after", 32'(ld_data), 32'h1A);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // 6: reset discards pending stores
    set_load(1'b1, 8'h90);
    set_store(1'b1, 8'h50, 8'h01);
    tick();
    set_store(1'b1, 8'h51, 8'h02);
    tick(); #1;
    check("t6_pending", 32'(count), 32'd2);
    set_store(1'b0, 8'h00, 8'h00);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("t6_cnt", 32'(count), 32'd0);
    check("t6_empty", 32'(buffer_empty), 32'd1);
    set_load(1'b1, 8'h50);
    #1;
    check("t6_hit", 32'(ld_hit), 32'd0);
    check("t6_data", 32'(ld_data), 32'h0A);
    set_load(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    check("t6_cnt_late", 32'(count), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
